// File: rtl/rob_if.sv
// rtl/rob_if.sv - rename/dispatch/writeback/commit bundle for the reorder buffer
interface rob_if #(
   parameter int TAG_WIDTH = 3
);
   typedef struct packed {
      logic                 we;
      logic [4:0]           addr;
      logic [TAG_WIDTH-1:0] tag;
      logic [31:0]          data;
   } prf_commit_write_port_t;

   logic [1:0]             rob_alloc_req;
   logic                   rob_alloc_en;
   logic [1:0]             rob_alloc_gnt;
   logic [TAG_WIDTH-1:0]   rob_tag0;
   logic [TAG_WIDTH-1:0]   rob_tag1;

   logic [1:0]             disp_val;
   logic [TAG_WIDTH-1:0]   disp_tag0;
   logic [TAG_WIDTH-1:0]   disp_tag1;
   logic [4:0]             disp_rd0;
   logic [4:0]             disp_rd1;
   logic [1:0]             disp_has_rd;

   logic [1:0]             wb_val;
   logic [TAG_WIDTH-1:0]   wb_tag0;
   logic [TAG_WIDTH-1:0]   wb_tag1;
   logic [31:0]            wb_data0;
   logic [31:0]            wb_data1;

   prf_commit_write_port_t commit_0_write_port;
   prf_commit_write_port_t commit_1_write_port;
   logic                   rob_empty;
   logic                   rob_full;

   modport master (
      output rob_alloc_req, rob_alloc_en,
      output disp_val, disp_tag0, disp_tag1, disp_rd0, disp_rd1, disp_has_rd,
      output wb_val, wb_tag0, wb_tag1, wb_data0, wb_data1,
      input  rob_alloc_gnt, rob_tag0, rob_tag1,
      input  commit_0_write_port, commit_1_write_port, rob_empty, rob_full
   );

   modport slave (
      input  rob_alloc_req, rob_alloc_en,
      input  disp_val, disp_tag0, disp_tag1, disp_rd0, disp_rd1, disp_has_rd,
      input  wb_val, wb_tag0, wb_tag1, wb_data0, wb_data1,
      output rob_alloc_gnt, rob_tag0, rob_tag1,
      output commit_0_write_port, commit_1_write_port, rob_empty, rob_full
   );
endinterface

// File: rtl/rob.sv
// rtl/rob.sv - two-wide circular reorder buffer with in-order dual commit
module rob #(
   parameter int TAG_WIDTH   = 3,
   parameter int ROB_ENTRIES = 2**TAG_WIDTH
) (
   input logic  clk,
   input logic  rst,
   input logic  flush,
   rob_if.slave bus
);
   localparam int CW = TAG_WIDTH + 1;

   logic [TAG_WIDTH-1:0]   head;
   logic [TAG_WIDTH-1:0]   tail;
   logic [CW-1:0]          count;
   logic [ROB_ENTRIES-1:0] valid;
   logic [ROB_ENTRIES-1:0] dispatched;
   logic [ROB_ENTRIES-1:0] done;
   logic [ROB_ENTRIES-1:0] has_rd;
   logic [4:0]             rd   [ROB_ENTRIES];
   logic [31:0]            data [ROB_ENTRIES];

   logic [TAG_WIDTH-1:0]   dtag  [2];
   logic [4:0]             drd   [2];
   logic [TAG_WIDTH-1:0]   wtag  [2];
   logic [31:0]            wdata [2];

   logic [CW-1:0]          n_req;
   logic [CW-1:0]          free;
   logic [CW-1:0]          n_alloc;
   logic [CW-1:0]          n_commit;
   logic [TAG_WIDTH-1:0]   head1;
   logic [TAG_WIDTH-1:0]   tag1;
   logic [1:0]             gnt;
   logic                   alloc_fire;
   logic                   c0;
   logic                   c1;
   logic                   kill;

   assign dtag[0]  = bus.disp_tag0;
   assign dtag[1]  = bus.disp_tag1;
   assign drd[0]   = bus.disp_rd0;
   assign drd[1]   = bus.disp_rd1;
   assign wtag[0]  = bus.wb_tag0;
   assign wtag[1]  = bus.wb_tag1;
   assign wdata[0] = bus.wb_data0;
   assign wdata[1] = bus.wb_data1;

   // grant, tag offer and commit selection, all from current state (free space is pre-commit)
   always_comb begin
      kill       = rst | flush;
      n_req      = CW'(bus.rob_alloc_req[0]) + CW'(bus.rob_alloc_req[1]);
      free       = CW'(ROB_ENTRIES) - count;
      gnt        = (free >= n_req) ? bus.rob_alloc_req : 2'b00;
      tag1       = bus.rob_alloc_req[0] ? tail + TAG_WIDTH'(1) : tail;
      alloc_fire = bus.rob_alloc_en && (gnt != 2'b00);
      n_alloc    = alloc_fire ? n_req : '0;
      head1      = head + TAG_WIDTH'(1);
      c0         = valid[head] & done[head] & ~kill;
      c1         = c0 & valid[head1] & done[head1];
      n_commit   = CW'(c0) + CW'(c1);

      bus.rob_alloc_gnt = gnt;
      bus.rob_tag0      = tail;
      bus.rob_tag1      = tag1;
      bus.rob_empty     = (count == '0);
      bus.rob_full      = (count == CW'(ROB_ENTRIES));

      bus.commit_0_write_port = '0;
      bus.commit_1_write_port = '0;
      if (c0) begin
         bus.commit_0_write_port.we   = has_rd[head] && (rd[head] != 5'd0);
         bus.commit_0_write_port.addr = rd[head];
         bus.commit_0_write_port.tag  = head;
         bus.commit_0_write_port.data = data[head];
      end
      if (c1) begin
         bus.commit_1_write_port.we   = has_rd[head1] && (rd[head1] != 5'd0);
         bus.commit_1_write_port.addr = rd[head1];
         bus.commit_1_write_port.tag  = head1;
         bus.commit_1_write_port.data = data[head1];
      end
   end

   // entry state and pointer update; later statements override earlier ones on the same entry
   always_ff @(posedge clk) begin
      if (kill) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         valid      <= '0;
         dispatched <= '0;
         done       <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (bus.disp_val[i] && valid[dtag[i]]) begin
               dispatched[dtag[i]] <= 1'b1;
               rd[dtag[i]]         <= drd[i];
               has_rd[dtag[i]]     <= bus.disp_has_rd[i];
            end
         end
         // port 1 first so port 0 wins on a duplicate tag
         for (int i = 1; i >= 0; i--) begin
            if (bus.wb_val[i] && valid[wtag[i]] && dispatched[wtag[i]]) begin
               done[wtag[i]] <= 1'b1;
               data[wtag[i]] <= wdata[i];
            end
         end
         if (c0) valid[head]  <= 1'b0;
         if (c1) valid[head1] <= 1'b0;
         if (alloc_fire) begin
            if (bus.rob_alloc_req[0]) begin
               valid[tail]      <= 1'b1;
               dispatched[tail] <= 1'b0;
               done[tail]       <= 1'b0;
            end
            if (bus.rob_alloc_req[1]) begin
               valid[tag1]      <= 1'b1;
               dispatched[tag1] <= 1'b0;
               done[tag1]       <= 1'b0;
            end
         end
         head  <= head + TAG_WIDTH'(n_commit);
         tail  <= tail + TAG_WIDTH'(n_alloc);
         count <= count + n_alloc - n_commit;
      end
   end
endmodule

// File: tb/tb_rob.sv
// tb/tb_rob.sv - directed and random checks of rob against an in-order queue model
module tb_rob;
   localparam int TW = 3;
   localparam int N  = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic flush = 1'b0;

   rob_if #(.TAG_WIDTH(TW)) bus ();

   rob #(.TAG_WIDTH(TW), .ROB_ENTRIES(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          tag;
      bit          disp;
      bit          done;
      bit          has_rd;
      int          rd;
      logic [31:0] data;
   } ent_t;

   ent_t q[$];
   int   m_head = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   logic [1:0]  o_gnt;
   logic [TW-1:0] o_tag0, o_tag1;
   logic [40:0] o_c0, o_c1;
   logic        o_empty, o_full;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int find(input int tag);
      int p;
      p = (tag - m_head + N) % N;
      return (p < q.size()) ? p : -1;
   endfunction

   function automatic logic [40:0] pack(input ent_t e);
      logic we;
      we = e.has_rd && (e.rd != 0);
      return {we, 5'(e.rd), TW'(e.tag), e.data};
   endfunction

   task automatic clr();
      bus.rob_alloc_req = 2'b00; bus.rob_alloc_en = 1'b0;
      bus.disp_val = 2'b00; bus.disp_tag0 = '0; bus.disp_tag1 = '0;
      bus.disp_rd0 = '0; bus.disp_rd1 = '0; bus.disp_has_rd = 2'b00;
      bus.wb_val = 2'b00; bus.wb_tag0 = '0; bus.wb_tag1 = '0;
      bus.wb_data0 = '0; bus.wb_data1 = '0;
      rst = 1'b0; flush = 1'b0;
   endtask

   // one clock: predict outputs from the model, compare at negedge, then advance the model
   task automatic step(input bit do_chk);
      logic [1:0]  req, egnt;
      logic [40:0] ec0, ec1;
      int sz, tl, nreq, et0, et1, p;
      bit kill, c0, c1;
      int dt[2], drd[2], wt[2];
      logic [31:0] wd[2];
      ent_t old[$];
      ent_t e;
      req  = bus.rob_alloc_req;
      sz   = q.size();
      tl   = (m_head + sz) % N;
      nreq = int'(req[0]) + int'(req[1]);
      egnt = (N - sz >= nreq) ? req : 2'b00;
      et0  = tl;
      et1  = req[0] ? (tl + 1) % N : tl;
      kill = rst || flush;
      c0   = !kill && sz > 0 && q[0].done;
      c1   = c0 && sz > 1 && q[1].done;
      ec0  = c0 ? pack(q[0]) : '0;
      ec1  = c1 ? pack(q[1]) : '0;
      @(negedge clk);
      o_gnt = bus.rob_alloc_gnt; o_tag0 = bus.rob_tag0; o_tag1 = bus.rob_tag1;
      o_c0 = bus.commit_0_write_port; o_c1 = bus.commit_1_write_port;
      o_empty = bus.rob_empty; o_full = bus.rob_full;
      if (do_chk) begin
         chk("gnt", 64'(o_gnt), 64'(egnt));
         chk("tag0", 64'(o_tag0), 64'(et0));
         chk("tag1", 64'(o_tag1), 64'(et1));
         chk("commit0", 64'(o_c0), 64'(ec0));
         chk("commit1", 64'(o_c1), 64'(ec1));
         chk("empty", 64'(o_empty), 64'(sz == 0));
         chk("full", 64'(o_full), 64'(sz == N));
      end
      if (kill) begin
         q.delete();
         m_head = 0;
      end else begin
         old = q;
         dt[0] = int'(bus.disp_tag0); dt[1] = int'(bus.disp_tag1);
         drd[0] = int'(bus.disp_rd0); drd[1] = int'(bus.disp_rd1);
         wt[0] = int'(bus.wb_tag0); wt[1] = int'(bus.wb_tag1);
         wd[0] = bus.wb_data0; wd[1] = bus.wb_data1;
         for (int i = 0; i < 2; i++) begin
            p = find(dt[i]);
            if (bus.disp_val[i] && p >= 0) begin
               q[p].disp = 1; q[p].rd = drd[i]; q[p].has_rd = bus.disp_has_rd[i];
            end
         end
         for (int i = 1; i >= 0; i--) begin
            p = find(wt[i]);
            if (bus.wb_val[i] && p >= 0 && old[p].disp) begin
               q[p].done = 1; q[p].data = wd[i];
            end
         end
         if (c0) void'(q.pop_front());
         if (c1) void'(q.pop_front());
         m_head = (m_head + int'(c0) + int'(c1)) % N;
         if (bus.rob_alloc_en && egnt != 2'b00) begin
            e = '{tag: 0, disp: 0, done: 0, has_rd: 0, rd: 0, data: '0};
            if (req[0]) begin e.tag = et0; q.push_back(e); end
            if (req[1]) begin e.tag = et1; q.push_back(e); end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr(); rst = 1'b1; step(1); clr();
   endtask

   task automatic alloc(input logic [1:0] r);
      clr(); bus.rob_alloc_req = r; bus.rob_alloc_en = 1'b1; step(1);
   endtask

   task automatic rand_cycle();
      int t0, t1;
      clr();
      bus.rob_alloc_req = 2'($urandom % 4);
      bus.rob_alloc_en  = ($urandom % 4) != 0;
      bus.disp_val      = 2'($urandom % 4);
      bus.disp_has_rd   = 2'($urandom % 4);
      bus.disp_rd0      = 5'($urandom % 4);
      bus.disp_rd1      = 5'($urandom);
      t0 = (q.size() > 0 && $urandom % 8 != 0) ? q[$urandom % q.size()].tag : int'($urandom % N);
      t1 = (q.size() > 0 && $urandom % 8 != 0) ? q[$urandom % q.size()].tag : int'($urandom % N);
      bus.disp_tag0 = TW'(t0); bus.disp_tag1 = TW'(t1);
      bus.wb_val    = 2'($urandom % 4);
      t0 = (q.size() > 0 && $urandom % 8 != 0) ? q[$urandom % q.size()].tag : int'($urandom % N);
      t1 = ($urandom % 6 == 0) ? t0 :
           ((q.size() > 0) ? q[$urandom % q.size()].tag : int'($urandom % N));
      bus.wb_tag0 = TW'(t0); bus.wb_tag1 = TW'(t1);
      bus.wb_data0 = $urandom; bus.wb_data1 = $urandom;
      flush = ($urandom % 60) == 0;
      rst   = ($urandom % 250) == 0;
      step(1);
   endtask

   initial begin
      clr();
      @(posedge clk); #1;
      rst = 1'b1; step(0); clr();

      // reset state, first dual allocation
      step(1);
      chk("rst_empty", 64'(o_empty), 64'd1);
      chk("rst_tag0", 64'(o_tag0), 64'd0);
      alloc(2'b11);
      chk("a37_gnt", 64'(o_gnt), 64'd3);
      chk("a37_tag1", 64'(o_tag1), 64'd1);
      clr(); step(1);
      chk("a37_next_tag0", 64'(o_tag0), 64'd2);

      // fill to N-1, dual request refused, single granted, then full
      do_reset();
      for (int k = 0; k < N - 1; k++) alloc(2'b01);
      alloc(2'b11);
      chk("fill_gnt00", 64'(o_gnt), 64'd0);
      alloc(2'b01);
      chk("fill_gnt01", 64'(o_gnt), 64'd1);
      clr(); step(1);
      chk("fill_full", 64'(o_full), 64'd1);

      // out-of-order writeback, in-order commit
      do_reset();
      alloc(2'b11);
      clr(); bus.disp_val = 2'b11; bus.disp_tag0 = 0; bus.disp_tag1 = 1;
      bus.disp_rd0 = 5; bus.disp_rd1 = 0; bus.disp_has_rd = 2'b11; step(1);
      clr(); bus.wb_val = 2'b01; bus.wb_tag0 = 1; bus.wb_data0 = 32'hAAAA_0001; step(1);
      clr(); bus.wb_val = 2'b01; bus.wb_tag0 = 0; bus.wb_data0 = 32'hBBBB_0000; step(1);
      chk("ooo_no_commit", 64'(o_c0), 64'd0);
      clr(); step(1);
      chk("ooo_c0", 64'(o_c0), 64'({1'b1, 5'd5, 3'd0, 32'hBBBB_0000}));
      chk("ooo_c1_we", 64'(o_c1[40]), 64'd0);
      chk("ooo_c1_tag", 64'(o_c1[34:32]), 64'd1);
      clr(); step(1);
      chk("ooo_empty", 64'(o_empty), 64'd1);

      // walk pointers to N-1, then allocate and commit across the wrap
      do_reset();
      for (int k = 0; k < N - 1; k++) begin
         alloc(2'b01);
         clr(); bus.disp_val = 2'b01; bus.disp_tag0 = TW'(k); bus.disp_rd0 = 1; bus.disp_has_rd = 2'b01; step(1);
         clr(); bus.wb_val = 2'b01; bus.wb_tag0 = TW'(k); bus.wb_data0 = k; step(1);
         clr(); step(1);
      end
      alloc(2'b11);
      chk("wrap_tag0", 64'(o_tag0), 64'(N - 1));
      chk("wrap_tag1", 64'(o_tag1), 64'd0);
      clr(); bus.disp_val = 2'b11; bus.disp_tag0 = TW'(N - 1); bus.disp_tag1 = 0;
      bus.disp_rd0 = 3; bus.disp_rd1 = 4; bus.disp_has_rd = 2'b11; step(1);
      clr(); bus.wb_val = 2'b11; bus.wb_tag0 = TW'(N - 1); bus.wb_tag1 = 0;
      bus.wb_data0 = 32'h77; bus.wb_data1 = 32'h88; step(1);
      clr(); step(1);
      chk("wrap_c0_tag", 64'(o_c0[34:32]), 64'(N - 1));
      chk("wrap_c1", 64'(o_c1), 64'({1'b1, 5'd4, 3'd0, 32'h88}));

      // requests without alloc_en change nothing
      do_reset();
      alloc(2'b01);
      for (int k = 0; k < 3; k++) begin
         clr(); bus.rob_alloc_req = 2'b11; step(1);
         chk("noen_gnt", 64'(o_gnt), 64'd3);
         chk("noen_tag0", 64'(o_tag0), 64'd1);
      end

      // flush with live, partly done entries; stale writebacks afterwards
      do_reset();
      for (int k = 0; k < 3; k++) alloc(2'b11);
      for (int k = 0; k < 3; k++) begin
         clr(); bus.disp_val = 2'b11; bus.disp_tag0 = TW'(2 * k); bus.disp_tag1 = TW'(2 * k + 1);
         bus.disp_rd0 = 7; bus.disp_rd1 = 8; bus.disp_has_rd = 2'b11; step(1);
      end
      clr(); bus.wb_val = 2'b11; bus.wb_tag0 = 0; bus.wb_tag1 = 1; bus.wb_data0 = 1; bus.wb_data1 = 2; step(1);
      clr(); flush = 1'b1; bus.wb_val = 2'b11; bus.wb_tag0 = 2; bus.wb_tag1 = 3; step(1);
      chk("flush_no_commit", 64'(o_c0), 64'd0);
      clr(); bus.wb_val = 2'b11; bus.wb_tag0 = 2; bus.wb_tag1 = 3; step(1);
      chk("flush_empty", 64'(o_empty), 64'd1);
      chk("flush_tag0", 64'(o_tag0), 64'd0);
      clr(); step(1);

      // randomized traffic
      for (int k = 0; k < 3000; k++) rand_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 Parameter ROB_ENTRIES, default 2**TAG_WIDTH, number of reorder-buffer entries; power of two, at least 4.
REQ-002 Parameter TAG_WIDTH, default uarch_pkg TAG_WIDTH, entry index width; equals log2(ROB_ENTRIES).
REQ-003 clk  in  1  single clock, all state updates on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 flush  in  1  synchronous pipeline flush.
REQ-006 rob_alloc_req  in  2  bit i set when rename slot i requests one entry.
REQ-007 rob_alloc_en  in  1  rename advancing this cycle (rename_rdy); allocation takes effect only when high.
REQ-008 rob_alloc_gnt  out  2  per-slot grant.
REQ-009 rob_tag0, rob_tag1  out  TAG_WIDTH each  tags offered to slots 0 and 1.
REQ-010 disp_val  in  2  per-slot dispatch write valid.
REQ-011 disp_tag0, disp_tag1  in  TAG_WIDTH each  entry written by dispatch.
REQ-012 disp_rd0, disp_rd1  in  5 each  architectural destination.
REQ-013 disp_has_rd  in  2  per-slot destination-present flag.
REQ-014 wb_val  in  2  writeback port valid, ports 0 and 1.
REQ-015 wb_tag0, wb_tag1  in  TAG_WIDTH each  completing entry.
REQ-016 wb_data0, wb_data1  in  32 each  result value.
REQ-017 commit_0_write_port, commit_1_write_port  out  prf_commit_write_port_t  fields we, addr, tag, data.
REQ-018 rob_empty, rob_full  out  1 each  occupancy status.

Function
REQ-019 Circular buffer: head pointer, tail pointer, count register (0..ROB_ENTRIES). Per-entry state: valid, dispatched, done, has_rd, rd, data.
REQ-020 n_req = popcount(rob_alloc_req); free = ROB_ENTRIES - count.
REQ-021 Grant is all-or-nothing and combinational: rob_alloc_gnt = rob_alloc_req when free >= n_req, else 2'b00.
REQ-022 rob_tag0 = tail. rob_tag1 = tail+1 when rob_alloc_req[0] is set, else tail. Both are modulo ROB_ENTRIES.
REQ-023 When rob_alloc_en is high and the grant is nonzero, the granted entries become valid with dispatched=0 and done=0, and tail advances by n_req at the next edge. When rob_alloc_en is low, there is no state change; grants remain a pure function of state.
REQ-024 Dispatch write with disp_val[i] set on a valid entry sets dispatched=1 and records rd and has_rd. A dispatch write to an invalid entry is ignored.
REQ-025 Writeback with wb_val[i] set on a valid, dispatched entry sets done=1 and stores data. Otherwise the writeback is ignored.
REQ-026 Commit is in order, up to 2 per cycle, combinational from current state:
- c0 = entry[head] valid and done.
- c1 = c0 and entry[head+1] valid and done.
REQ-027 commit_k_write_port for committed entry e:
- we = has_rd and (rd != 0)
- addr = rd
- tag = e
- data = e.data
All fields are 0 when the slot is not committing.
REQ-028 Committed entries are cleared (valid=0). Head advances by c0+c1 at the next edge.
REQ-029 count_next = count + allocated - committed. Allocation and commit in the same cycle are both honored. Free space is computed from pre-commit count (no same-cycle reuse).
REQ-030 Writeback arriving the same cycle as the head check is not visible to commit until the next cycle.
REQ-031 Pointers wrap from ROB_ENTRIES-1 to 0. An allocation or commit straddling the wrap point is legal.
REQ-032 rob_empty = (count==0). rob_full = (count==ROB_ENTRIES).
REQ-033 Duplicate writeback tags in one cycle: port 0 data wins.

Reset
REQ-034 On rst or flush at posedge:
- head = tail = count = 0
- all entry valid, dispatched and done bits cleared
- all same-cycle allocation, writeback and commit are discarded
REQ-035 Outputs after reset: rob_empty=1, rob_full=0, rob_tag0=0. commit ports all-zero. rob_alloc_gnt = rob_alloc_req (subject to REQ-021).
REQ-036 rst and flush are asserted mid-operation with the same effect. Flush has priority over all other inputs.

Verification
REQ-037 After reset, req=11, alloc_en=1 -> gnt=11, tag0=0, tag1=1. Next cycle count=2, tag0=2.
REQ-038 Fill to ROB_ENTRIES-1, then req=11 -> gnt=00 with no state change. Then req=01 -> gnt=01, then rob_full=1.
REQ-039 Allocate tags 0 and 1 with dispatch rd=5 and rd=0. Writeback tag1 first, then tag0 one cycle later. Required sequence:
- no commit after tag1 writeback alone
- next cycle commit_0 we=1 addr=5 tag=0 data=wb; commit_1 we=0 tag=1
- count returns to 0
REQ-040 Wrap: head=tail=ROB_ENTRIES-1, req=11 -> tags ROB_ENTRIES-1 and 0. Commit of both succeeds in one cycle.
REQ-041 req=11 with alloc_en=0 for 3 cycles -> gnt=11 each cycle with tag0 unchanged and count unchanged.
REQ-042 flush with 6 entries live, some done -> no commit that cycle. Next cycle empty, tag0=0, stale writebacks ignored.
